// File: rtl/i2s_tdm_rx.sv
// I2S / TDM serial audio receiver: oversamples bclk/ws/sd in the clk domain, deserialises
// slots into words and hands them out through a small first-word-fall-through FIFO.
`timescale 1ns/1ps
module i2s_tdm_rx #(
    parameter int W_DATA = 24,
    parameter int W_SLOT = 32,
    parameter int N_CH   = 2,
    parameter int DEPTH  = 4,
    localparam int W_CH  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bclk,
    input  logic              ws,
    input  logic              sd,
    input  logic              mode,
    output logic [W_DATA-1:0] m_data,
    output logic [W_CH-1:0]   m_ch,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              locked,
    output logic              frame_err,
    output logic              overrun
);
    localparam int TOTAL = N_CH * W_SLOT;
    localparam int W_CNT = $clog2(TOTAL + 2);
    localparam int W_BIT = $clog2(W_SLOT);
    localparam int W_PTR = $clog2(DEPTH);

    typedef enum logic {SYNC, RUN} state_t;

    logic [2:0]              r_sync1, r_sync2;
    logic                    r_bclk_d, r_ws_prev;
    state_t                  r_state, w_state_next;
    logic [W_BIT-1:0]        r_bit, w_bit_use, w_bit_next;
    logic [W_CH-1:0]         r_slot, w_slot_use, w_slot_next;
    logic [W_CNT-1:0]        r_cnt, w_cnt_use, w_cnt_next;
    logic                    r_done, w_done_use, w_done_next;
    logic [W_DATA-1:0]       r_shift, w_shift_next;
    logic                    r_frame_err, r_overrun;
    logic                    w_rise, w_ws, w_sd, w_fs, w_take, w_err, w_push;

    logic [W_DATA+W_CH-1:0]  r_mem [DEPTH];
    logic [W_PTR:0]          r_wr_ptr, r_rd_ptr;
    logic [W_DATA+W_CH-1:0]  w_head;
    logic                    w_empty, w_full, w_pop, w_wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_bclk_d <= 1'b0;
        end else begin
            r_sync1  <= {bclk, ws, sd};
            r_sync2  <= r_sync1;
            r_bclk_d <= r_sync2[2];
        end
    end

    assign w_rise = r_sync2[2] & ~r_bclk_d;
    assign w_ws   = r_sync2[1];
    assign w_sd   = r_sync2[0];
    assign w_fs   = w_rise & ~w_ws & r_ws_prev;

    always_comb begin
        w_state_next = r_state;
        if (r_state == SYNC && w_fs)
            w_state_next = RUN;
    end

    // In I2S mode the frame-start rise still carries the last bit of the previous frame,
    // so it is consumed with the old counters before they restart.
    always_comb begin
        w_bit_use    = r_bit;
        w_slot_use   = r_slot;
        w_cnt_use    = r_cnt;
        w_done_use   = r_done;
        w_bit_next   = r_bit;
        w_slot_next  = r_slot;
        w_cnt_next   = r_cnt;
        w_done_next  = r_done;
        w_shift_next = r_shift;
        w_take       = 1'b0;
        w_err        = 1'b0;
        w_push       = 1'b0;
        if (w_rise) begin
            if (w_fs && mode) begin
                w_err      = (r_state == RUN) && (r_cnt != W_CNT'(TOTAL));
                w_bit_use  = '0;
                w_slot_use = '0;
                w_cnt_use  = '0;
                w_done_use = 1'b0;
                w_take     = 1'b1;
            end else begin
                w_take = (r_state == RUN);
            end
            if (w_take) begin
                w_cnt_next  = (w_cnt_use == W_CNT'(TOTAL + 1)) ? w_cnt_use : w_cnt_use + 1'b1;
                w_bit_next  = w_bit_use;
                w_slot_next = w_slot_use;
                w_done_next = w_done_use;
                if (!w_done_use) begin
                    if (int'(w_bit_use) < W_DATA)
                        w_shift_next = {r_shift[W_DATA-2:0], w_sd};
                    if (int'(w_bit_use) == W_SLOT - 1) begin
                        w_push     = 1'b1;
                        w_bit_next = '0;
                        if (int'(w_slot_use) == N_CH - 1)
                            w_done_next = 1'b1;
                        else
                            w_slot_next = w_slot_use + 1'b1;
                    end else begin
                        w_bit_next = w_bit_use + 1'b1;
                    end
                end
            end
            if (w_fs && !mode) begin
                w_err       = (r_state == RUN) && (w_cnt_next != W_CNT'(TOTAL));
                w_bit_next  = '0;
                w_slot_next = '0;
                w_cnt_next  = '0;
                w_done_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SYNC;
            r_ws_prev   <= 1'b0;
            r_bit       <= '0;
            r_slot      <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            if (w_rise)
                r_ws_prev <= w_ws;
            r_bit       <= w_bit_next;
            r_slot      <= w_slot_next;
            r_cnt       <= w_cnt_next;
            r_done      <= w_done_next;
            r_shift     <= w_shift_next;
            r_frame_err <= w_err;
            r_overrun   <= w_push & w_full & ~w_pop;
        end
    end

    // A full FIFO still accepts a push when the head is leaving in the same cycle.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[W_PTR] != r_rd_ptr[W_PTR]) &&
                     (r_wr_ptr[W_PTR-1:0] == r_rd_ptr[W_PTR-1:0]);
    assign w_pop   = ~w_empty & m_ready;
    assign w_wr_en = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr[W_PTR-1:0]] <= {w_slot_use, w_shift_next};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign w_head    = r_mem[r_rd_ptr[W_PTR-1:0]];
    assign m_valid   = ~w_empty;
    assign m_data    = w_empty ? '0 : w_head[W_DATA-1:0];
    assign m_ch      = w_empty ? '0 : w_head[W_DATA+W_CH-1:W_DATA];
    assign locked    = (r_state == RUN);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_i2s_tdm_rx.sv
// Scoreboard bench for i2s_tdm_rx: a stereo 24/32 instance and an 8-slot TDM 16/32 instance
// share one serial stream; whichever instance is not under test is held in reset.
`timescale 1ns/1ps
module tb_i2s_tdm_rx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, bclk, ws, sd, mode_a, mode_b, ready_a, ready_b;
    logic [23:0] data_a;
    logic        ch_a;
    logic        valid_a, locked_a, ferr_a, ovr_a;
    logic [15:0] data_b;
    logic [2:0]  ch_b;
    logic        valid_b, locked_b, ferr_b, ovr_b;

    i2s_tdm_rx dut_a (
        .clk(clk), .rst(rst_a), .bclk(bclk), .ws(ws), .sd(sd), .mode(mode_a),
        .m_data(data_a), .m_ch(ch_a), .m_valid(valid_a), .m_ready(ready_a),
        .locked(locked_a), .frame_err(ferr_a), .overrun(ovr_a)
    );

    i2s_tdm_rx #(.W_DATA(16), .W_SLOT(32), .N_CH(8), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst_b), .bclk(bclk), .ws(ws), .sd(sd), .mode(mode_b),
        .m_data(data_b), .m_ch(ch_b), .m_valid(valid_b), .m_ready(ready_b),
        .locked(locked_b), .frame_err(ferr_b), .overrun(ovr_b)
    );

    typedef struct {
        logic [31:0] data;
        int          ch;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        e_a, e_b;
    int          errors = 0;
    int          checks = 0;
    int          ferr_cnt_a = 0, ovr_cnt_a = 0, ferr_cnt_b = 0, ovr_cnt_b = 0;
    int          f0, o0;
    logic [31:0] tx_word [16];

    // Monitors: pop the scoreboard whenever a word is handed over.
    always @(negedge clk) begin
        if (ferr_a) ferr_cnt_a++;
        if (ovr_a)  ovr_cnt_a++;
        if (ferr_b) ferr_cnt_b++;
        if (ovr_b)  ovr_cnt_b++;
        if (valid_a && ready_a) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL a_word: got data=%h ch=%0d, required no word", data_a, ch_a);
            end else begin
                e_a = q_a.pop_front();
                if (data_a !== e_a.data[23:0] || ch_a !== e_a.ch[0]) begin
                    errors++;
                    $display("FAIL a_word: got data=%h ch=%0d, required data=%h ch=%0d",
                             data_a, ch_a, e_a.data[23:0], e_a.ch);
                end else
                    $display("ok   a_word: data=%h ch=%0d", data_a, ch_a);
            end
        end
        if (valid_b && ready_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL b_word: got data=%h ch=%0d, required no word", data_b, ch_b);
            end else begin
                e_b = q_b.pop_front();
                if (data_b !== e_b.data[15:0] || ch_b !== e_b.ch[2:0]) begin
                    errors++;
                    $display("FAIL b_word: got data=%h ch=%0d, required data=%h ch=%0d",
                             data_b, ch_b, e_b.data[15:0], e_b.ch);
                end else
                    $display("ok   b_word: data=%h ch=%0d", data_b, ch_b);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else
            $display("ok   %s: %h", name, act);
    endtask

    task automatic rise_bit(input logic w, input logic d);
        ws = w;
        sd = d;
        #40 bclk = 1'b1;
        #40 bclk = 1'b0;
    endtask

    task automatic preamble();
        rise_bit(1'b1, 1'b0);
        rise_bit(1'b1, 1'b0);
    endtask

    // One frame of len rises; ws low for the first half; data delayed by dly rises.
    task automatic send_frame(input int nch, input int wslot, input int wdata, input int len, input int dly);
        for (int k = 0; k < len; k++) begin
            int   p, s, b;
            logic d;
            p = k - dly;
            d = 1'b0;
            if (p >= 0) begin
                s = p / wslot;
                b = p % wslot;
                if (b < wdata && s < nch) d = tx_word[s][wdata-1-b];
            end
            rise_bit((k < len / 2) ? 1'b0 : 1'b1, d);
        end
    endtask

    task automatic exp_a(input logic [31:0] d, input int c);
        q_a.push_back('{d, c});
    endtask

    task automatic wait_empty_a(input string name);
        for (int i = 0; i < 400 && q_a.size() != 0; i++) @(negedge clk);
        check(name, q_a.size(), 0);
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_a = 1'b0;
    endtask

    task automatic stereo(input logic [31:0] l, input logic [31:0] r, input int dly);
        tx_word[0] = l;
        tx_word[1] = r;
        send_frame(2, 32, 24, 64, dly);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; bclk = 1'b0; ws = 1'b0; sd = 1'b0;
        mode_a = 1'b0; mode_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        repeat (3) @(negedge clk);
        check("a_reset_outputs", {valid_a, locked_a, ferr_a, ovr_a, ch_a, data_a}, 32'h0);
        @(posedge clk);
        #2 rst_a = 1'b0;

        // I2S stereo, two frames
        f0 = ferr_cnt_a;
        exp_a(32'hABCDEF, 0); exp_a(32'h123456, 1);
        exp_a(32'hABCDEF, 0); exp_a(32'h123456, 1);
        preamble();
        check("t1_locked_before_fs", locked_a, 0);
        stereo(32'hABCDEF, 32'h123456, 1);
        check("t1_locked_after_fs", locked_a, 1);
        stereo(32'hABCDEF, 32'h123456, 1);
        rise_bit(1'b0, 1'b0);
        wait_empty_a("t1_drain");
        check("t1_frame_err", ferr_cnt_a - f0, 0);

        // left-justified stream, mode=1
        reset_a();
        mode_a = 1'b1;
        f0 = ferr_cnt_a;
        exp_a(32'hABCDEF, 0); exp_a(32'h123456, 1);
        preamble();
        stereo(32'hABCDEF, 32'h123456, 0);
        rise_bit(1'b0, 1'b0);
        wait_empty_a("t2_drain");
        check("t2_frame_err", ferr_cnt_a - f0, 0);

        // left-justified stream read as I2S: words shift left by one
        reset_a();
        mode_a = 1'b0;
        exp_a(32'h579BDE, 0); exp_a(32'h2468AC, 1);
        preamble();
        stereo(32'hABCDEF, 32'h123456, 0);
        rise_bit(1'b0, 1'b0);
        wait_empty_a("t3_drain");

        // short frame of 40 bits
        reset_a();
        f0 = ferr_cnt_a;
        exp_a(32'hABCDEF, 0); exp_a(32'h123456, 1);
        exp_a(32'h111111, 0);
        exp_a(32'h654321, 0); exp_a(32'hFEDCBA, 1);
        preamble();
        stereo(32'hABCDEF, 32'h123456, 1);
        tx_word[0] = 32'h111111;
        tx_word[1] = 32'h222222;
        send_frame(2, 32, 24, 40, 1);
        stereo(32'h654321, 32'hFEDCBA, 1);
        rise_bit(1'b0, 1'b0);
        wait_empty_a("t4_drain");
        check("t4_frame_err", ferr_cnt_a - f0, 1);

        // overrun: three frames with the sink stalled
        reset_a();
        ready_a = 1'b0;
        f0 = ferr_cnt_a;
        o0 = ovr_cnt_a;
        exp_a(32'h100001, 0); exp_a(32'h100002, 1);
        exp_a(32'h100003, 0); exp_a(32'h100004, 1);
        preamble();
        stereo(32'h100001, 32'h100002, 1);
        stereo(32'h100003, 32'h100004, 1);
        stereo(32'h100005, 32'h100006, 1);
        rise_bit(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("t5_valid_held", valid_a, 1);
        check("t5_overrun", ovr_cnt_a - o0, 2);
        @(posedge clk);
        #2 ready_a = 1'b1;
        wait_empty_a("t5_drain");
        repeat (20) @(negedge clk);
        check("t5_frame_err", ferr_cnt_a - f0, 0);

        // reset mid-slot with two words held
        reset_a();
        ready_a = 1'b0;
        preamble();
        stereo(32'hAAAAAA, 32'h555555, 1);
        rise_bit(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("t6_valid_before_rst", valid_a, 1);
        for (int i = 0; i < 10; i++) rise_bit(1'b0, 1'b1);
        #3 rst_a = 1'b1;
        #1;
        check("t6_valid_in_rst", valid_a, 0);
        check("t6_locked_in_rst", locked_a, 0);
        repeat (3) @(posedge clk);
        #2 rst_a = 1'b0;
        ready_a = 1'b1;
        for (int i = 0; i < 4; i++) rise_bit(1'b1, 1'b1);
        check("t6_locked_before_fs", locked_a, 0);
        check("t6_valid_before_fs", valid_a, 0);
        rise_bit(1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("t6_locked_after_fs", locked_a, 1);
        for (int i = 0; i < 10; i++) rise_bit(1'b0, 1'b1);
        check("t6_no_word", valid_a, 0);
        rst_a = 1'b1;

        // TDM, 8 slots of 16-bit words in 32-bit slots
        repeat (3) @(posedge clk);
        #2 rst_b = 1'b0;
        f0 = ferr_cnt_b;
        o0 = ovr_cnt_b;
        for (int k = 0; k < 8; k++) begin
            tx_word[k] = 32'h1000 + k;
            q_b.push_back('{32'h1000 + k, k});
        end
        preamble();
        send_frame(8, 32, 16, 256, 1);
        rise_bit(1'b0, 1'b0);
        for (int i = 0; i < 400 && q_b.size() != 0; i++) @(negedge clk);
        check("t7_drain", q_b.size(), 0);
        check("t7_frame_err", ferr_cnt_b - f0, 0);
        check("t7_overrun", ovr_cnt_b - o0, 0);
        rst_b = 1'b1;

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
